// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC and keeps at most one word request outstanding to instruction
// memory. A one-entry skid buffer absorbs a response that arrives while IF/ID
// is stalled. Redirects flush the presented slot and the skid. A response
// still in flight during a redirect is drained and discarded.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic [31:0] adder_out,
  output logic        fetch_valid
);

  // FETCH: may issue a request; WAIT: one request outstanding;
  // HOLD: response parked in skid until IF/ID frees the slot;
  // DRAIN: outstanding response belongs to a flushed path.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Clear the two byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic        r_fetch_valid;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic [31:0] r_adder_out;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_req_addr_nxt;
  logic        w_skid_valid_nxt;
  logic [31:0] w_skid_pc_nxt;
  logic [31:0] w_skid_instr_nxt;
  logic        w_fetch_valid_nxt;
  logic [31:0] w_pc_out_nxt;
  logic [31:0] w_instr_out_nxt;
  logic [31:0] w_adder_out_nxt;

  logic        w_req;
  logic        w_accept;
  logic        w_consume;
  logic        w_slot_free;

  // A request is offered only from FETCH and never in a redirect cycle, so
  // the old path cannot get a request accepted while the PC is being replaced.
  assign w_req       = (r_state == ST_FETCH) & ~redirect_valid;
  assign w_accept    = w_req & imem_ready;
  assign w_consume   = r_fetch_valid & ~stall;
  assign w_slot_free = ~r_fetch_valid | w_consume;

  assign imem_req        = w_req;
  assign imem_addr       = r_pc;
  assign PC_out          = r_pc_out;
  assign instruction_out = r_instr_out;
  assign adder_out       = r_adder_out;
  assign fetch_valid     = r_fetch_valid;

  // Next-state and next-datapath decode; redirect has priority over everything.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_req_addr_nxt    = r_req_addr;
    w_skid_valid_nxt  = r_skid_valid;
    w_skid_pc_nxt     = r_skid_pc;
    w_skid_instr_nxt  = r_skid_instr;
    w_fetch_valid_nxt = r_fetch_valid;
    w_pc_out_nxt      = r_pc_out;
    w_instr_out_nxt   = r_instr_out;
    w_adder_out_nxt   = r_adder_out;

    if (redirect_valid) begin
      w_pc_nxt          = word_align(redirect_pc);
      w_fetch_valid_nxt = 1'b0;
      w_instr_out_nxt   = NOP_INSTR;
      w_skid_valid_nxt  = 1'b0;
      w_skid_pc_nxt     = 32'h0000_0000;
      w_skid_instr_nxt  = 32'h0000_0000;
      case (r_state)
        ST_WAIT: begin
          // A response landing in the redirect cycle is simply dropped;
          // otherwise it is still coming and must be drained.
          if (imem_rvalid) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: w_state_nxt = ST_DRAIN;
        default:  w_state_nxt = ST_FETCH;
      endcase
    end else begin
      if (w_accept) begin
        w_pc_nxt       = next_word(r_pc);
        w_req_addr_nxt = r_pc;
      end else begin
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
      end

      // Consuming the presented instruction leaves a bubble unless something
      // new is loaded below in the same cycle.
      if (w_consume) begin
        w_fetch_valid_nxt = 1'b0;
        w_instr_out_nxt   = NOP_INSTR;
      end else begin
        w_fetch_valid_nxt = r_fetch_valid;
        w_instr_out_nxt   = r_instr_out;
      end

      case (r_state)
        ST_FETCH: begin
          if (w_accept) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (w_slot_free) begin
              w_fetch_valid_nxt = 1'b1;
              w_pc_out_nxt      = r_req_addr;
              w_instr_out_nxt   = imem_rdata;
              w_adder_out_nxt   = next_word(r_req_addr);
              w_state_nxt       = ST_FETCH;
            end else begin
              w_skid_valid_nxt  = 1'b1;
              w_skid_pc_nxt     = r_req_addr;
              w_skid_instr_nxt  = imem_rdata;
              w_state_nxt       = ST_HOLD;
            end
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (w_consume & r_skid_valid) begin
            w_fetch_valid_nxt = 1'b1;
            w_pc_out_nxt      = r_skid_pc;
            w_instr_out_nxt   = r_skid_instr;
            w_adder_out_nxt   = next_word(r_skid_pc);
            w_skid_valid_nxt  = 1'b0;
            w_state_nxt       = ST_FETCH;
          end else if (~r_skid_valid) begin
            // Empty skid in HOLD cannot occur; recover to FETCH rather than lock up.
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, outstanding-request address, skid buffer and IF/ID output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_req_addr    <= 32'h0000_0000;
      r_skid_valid  <= 1'b0;
      r_skid_pc     <= 32'h0000_0000;
      r_skid_instr  <= 32'h0000_0000;
      r_fetch_valid <= 1'b0;
      r_pc_out      <= 32'h0000_0000;
      r_instr_out   <= NOP_INSTR;
      r_adder_out   <= 32'h0000_0000;
    end else begin
      r_pc          <= w_pc_nxt;
      r_req_addr    <= w_req_addr_nxt;
      r_skid_valid  <= w_skid_valid_nxt;
      r_skid_pc     <= w_skid_pc_nxt;
      r_skid_instr  <= w_skid_instr_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_instr_out   <= w_instr_out_nxt;
      r_adder_out   <= w_adder_out_nxt;
    end
  end

endmodule
